// File: rtl/decode_sequencer.sv
// ============================================================================
// Module   : decode_sequencer
// Summary  : Decode-side sequencer. It assembles two-word immediates, runs the
//            interrupt entry micro-op sequence and gates fetch.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_sequencer #(
    parameter logic [4:0]  OP_LDM   = 5'b10100,
    parameter logic [4:0]  OP_IADD  = 5'b10101,
    parameter logic [15:0] VEC_INT1 = 16'h0000,
    parameter logic [15:0] VEC_INT2 = 16'h0002
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  opcode_decode,
    input  logic [2:0]  Rs_decode,
    input  logic [2:0]  Rd_decode,
    input  logic [4:0]  shmnt_decode,
    input  logic [31:0] pc_decode,
    input  logic        int1_decode,
    input  logic        int2_decode,
    input  logic        stall_in,
    output logic        fd_enable,
    output logic        busy,
    output logic        de_valid,
    output logic [2:0]  de_uop,
    output logic [4:0]  de_opcode,
    output logic [2:0]  de_rs,
    output logic [2:0]  de_rd,
    output logic [4:0]  de_shmnt,
    output logic [15:0] de_imm,
    output logic [31:0] de_pc
);

    localparam logic [2:0] c_UOP_NORMAL     = 3'd0;
    localparam logic [2:0] c_UOP_IMM        = 3'd1;
    localparam logic [2:0] c_UOP_PUSH_PC    = 3'd2;
    localparam logic [2:0] c_UOP_PUSH_FLAGS = 3'd3;
    localparam logic [2:0] c_UOP_INT_JUMP   = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IMM     = 3'd1,
        S_INT_PC  = 3'd2,
        S_INT_FLG = 3'd3,
        S_INT_JMP = 3'd4,
        S_DRAIN   = 3'd5
    } state_t;

    state_t      r_state, w_state_nxt;
    logic        r_pend, w_pend_nxt;
    logic        r_src, w_src_nxt;           // 0 = int1, 1 = int2
    logic [4:0]  r_hold_op, w_hold_op_nxt;
    logic [2:0]  r_hold_rs, w_hold_rs_nxt;
    logic [2:0]  r_hold_rd, w_hold_rd_nxt;
    logic [31:0] r_hold_pc, w_hold_pc_nxt;

    logic        r_valid, w_valid_nxt;
    logic [2:0]  r_uop, w_uop_nxt;
    logic [4:0]  r_op, w_op_nxt;
    logic [2:0]  r_rs, w_rs_nxt;
    logic [2:0]  r_rd, w_rd_nxt;
    logic [4:0]  r_sh, w_sh_nxt;
    logic [15:0] r_imm, w_imm_nxt;
    logic [31:0] r_pc, w_pc_nxt;

    assign fd_enable = !stall_in && (r_state != S_INT_PC) && (r_state != S_INT_FLG);
    assign busy      = (r_state != S_IDLE);
    assign de_valid  = r_valid;
    assign de_uop    = r_uop;
    assign de_opcode = r_op;
    assign de_rs     = r_rs;
    assign de_rd     = r_rd;
    assign de_shmnt  = r_sh;
    assign de_imm    = r_imm;
    assign de_pc     = r_pc;

    always_comb begin
        w_state_nxt   = r_state;
        w_pend_nxt    = r_pend;
        w_src_nxt     = r_src;
        w_hold_op_nxt = r_hold_op;
        w_hold_rs_nxt = r_hold_rs;
        w_hold_rd_nxt = r_hold_rd;
        w_hold_pc_nxt = r_hold_pc;
        w_valid_nxt   = 1'b0;
        w_uop_nxt     = c_UOP_NORMAL;
        w_op_nxt      = r_op;
        w_rs_nxt      = r_rs;
        w_rd_nxt      = r_rd;
        w_sh_nxt      = r_sh;
        w_imm_nxt     = r_imm;
        w_pc_nxt      = r_pc;

        if (!stall_in) begin
            case (r_state)
                S_IDLE: begin
                    if (int1_decode || int2_decode || r_pend) begin
                        // Presented word is dropped; its PC becomes the return address.
                        w_valid_nxt   = 1'b1;
                        w_uop_nxt     = c_UOP_PUSH_PC;
                        w_pc_nxt      = pc_decode;
                        w_hold_pc_nxt = pc_decode;
                        w_src_nxt     = int1_decode ? 1'b0 : (r_pend ? r_src : 1'b1);
                        w_pend_nxt    = 1'b0;
                        w_state_nxt   = S_INT_PC;
                    end else if (opcode_decode == OP_LDM || opcode_decode == OP_IADD) begin
                        w_hold_op_nxt = opcode_decode;
                        w_hold_rs_nxt = Rs_decode;
                        w_hold_rd_nxt = Rd_decode;
                        w_hold_pc_nxt = pc_decode;
                        w_state_nxt   = S_IMM;
                    end else begin
                        w_valid_nxt = 1'b1;
                        w_uop_nxt   = c_UOP_NORMAL;
                        w_op_nxt    = opcode_decode;
                        w_rs_nxt    = Rs_decode;
                        w_rd_nxt    = Rd_decode;
                        w_sh_nxt    = shmnt_decode;
                        w_imm_nxt   = 16'h0000;
                        w_pc_nxt    = pc_decode;
                    end
                end
                S_IMM: begin
                    w_valid_nxt = 1'b1;
                    w_uop_nxt   = c_UOP_IMM;
                    w_op_nxt    = r_hold_op;
                    w_rs_nxt    = r_hold_rs;
                    w_rd_nxt    = r_hold_rd;
                    w_sh_nxt    = 5'd0;
                    w_pc_nxt    = r_hold_pc;
                    w_imm_nxt   = {opcode_decode, Rs_decode, Rd_decode, shmnt_decode};
                    // An interrupt tagged on the data word is deferred to the next IDLE cycle.
                    if (int1_decode || int2_decode) begin
                        w_pend_nxt = 1'b1;
                        w_src_nxt  = !int1_decode;
                    end
                    w_state_nxt = S_IDLE;
                end
                S_INT_PC: begin
                    w_valid_nxt = 1'b1;
                    w_uop_nxt   = c_UOP_PUSH_FLAGS;
                    w_pc_nxt    = r_hold_pc;
                    w_state_nxt = S_INT_FLG;
                end
                S_INT_FLG: begin
                    w_valid_nxt = 1'b1;
                    w_uop_nxt   = c_UOP_INT_JUMP;
                    w_imm_nxt   = r_src ? VEC_INT2 : VEC_INT1;
                    w_state_nxt = S_INT_JMP;
                end
                S_INT_JMP: w_state_nxt = S_DRAIN;
                S_DRAIN:   w_state_nxt = S_IDLE;
                default:   w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Negedge update matches the write-at-negedge pipeline-register timing.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_pend    <= 1'b0;
            r_src     <= 1'b0;
            r_hold_op <= 5'd0;
            r_hold_rs <= 3'd0;
            r_hold_rd <= 3'd0;
            r_hold_pc <= 32'd0;
            r_valid   <= 1'b0;
            r_uop     <= c_UOP_NORMAL;
            r_op      <= 5'd0;
            r_rs      <= 3'd0;
            r_rd      <= 3'd0;
            r_sh      <= 5'd0;
            r_imm     <= 16'd0;
            r_pc      <= 32'd0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_src     <= w_src_nxt;
            r_hold_op <= w_hold_op_nxt;
            r_hold_rs <= w_hold_rs_nxt;
            r_hold_rd <= w_hold_rd_nxt;
            r_hold_pc <= w_hold_pc_nxt;
            r_valid   <= w_valid_nxt;
            r_uop     <= w_uop_nxt;
            r_op      <= w_op_nxt;
            r_rs      <= w_rs_nxt;
            r_rd      <= w_rd_nxt;
            r_sh      <= w_sh_nxt;
            r_imm     <= w_imm_nxt;
            r_pc      <= w_pc_nxt;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_decode_sequencer.sv
// ============================================================================
// Module   : tb_decode_sequencer
// Summary  : Directed bench for decode_sequencer with a cycle model and checks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_sequencer;

    localparam logic [4:0] c_OP_LDM  = 5'b10100;
    localparam logic [4:0] c_OP_IADD = 5'b10101;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  opcode_decode = '0;
    logic [2:0]  Rs_decode = '0;
    logic [2:0]  Rd_decode = '0;
    logic [4:0]  shmnt_decode = '0;
    logic [31:0] pc_decode = '0;
    logic        int1_decode = 1'b0;
    logic        int2_decode = 1'b0;
    logic        stall_in = 1'b0;
    logic        fd_enable, busy, de_valid;
    logic [2:0]  de_uop;
    logic [4:0]  de_opcode, de_shmnt;
    logic [2:0]  de_rs, de_rd;
    logic [15:0] de_imm;
    logic [31:0] de_pc;

    int errors = 0;
    int checks = 0;

    decode_sequencer dut (
        .clk(clk), .rst_n(rst_n),
        .opcode_decode(opcode_decode), .Rs_decode(Rs_decode), .Rd_decode(Rd_decode),
        .shmnt_decode(shmnt_decode), .pc_decode(pc_decode),
        .int1_decode(int1_decode), .int2_decode(int2_decode), .stall_in(stall_in),
        .fd_enable(fd_enable), .busy(busy), .de_valid(de_valid), .de_uop(de_uop),
        .de_opcode(de_opcode), .de_rs(de_rs), .de_rd(de_rd), .de_shmnt(de_shmnt),
        .de_imm(de_imm), .de_pc(de_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: where the sequence is (steps after interrupt entry, waiting for immediate)
    int          m_step = 0;     // 0 none, 1 PUSH_FLAGS next, 2 JUMP next, 3/4 bubbles
    bit          m_immw = 0;
    bit          m_pend = 0;
    int          m_src  = 1;     // 1 or 2
    logic [4:0]  m_op = '0;
    logic [2:0]  m_rs = '0, m_rd = '0;
    logic [31:0] m_pc = '0;
    bit          e_valid = 0;
    int          e_uop = 0;
    logic [4:0]  e_op = '0, e_sh = '0;
    logic [2:0]  e_rs = '0, e_rd = '0;
    logic [15:0] e_imm = '0;
    logic [31:0] e_pc = '0;

    task automatic model_reset();
        m_step = 0; m_immw = 0; m_pend = 0; m_src = 1;
        e_valid = 0; e_uop = 0;
    endtask

    task automatic model_step();
        e_valid = 0; e_uop = 0;
        if (stall_in) return;
        if (m_step != 0) begin
            case (m_step)
                1: begin e_valid = 1; e_uop = 3; e_pc = m_pc; end
                2: begin e_valid = 1; e_uop = 4; e_imm = (m_src == 1) ? 16'h0000 : 16'h0002; end
                default: ;
            endcase
            m_step = (m_step == 4) ? 0 : m_step + 1;
        end else if (m_immw) begin
            e_valid = 1; e_uop = 1;
            e_op = m_op; e_rs = m_rs; e_rd = m_rd; e_pc = m_pc;
            e_imm = 16'(opcode_decode * 2048 + Rs_decode * 256 + Rd_decode * 32 + shmnt_decode);
            if (int1_decode || int2_decode) begin
                m_pend = 1;
                m_src  = int1_decode ? 1 : 2;
            end
            m_immw = 0;
        end else if (int1_decode || int2_decode || m_pend) begin
            e_valid = 1; e_uop = 2; e_pc = pc_decode; m_pc = pc_decode;
            m_src  = int1_decode ? 1 : (m_pend ? m_src : 2);
            m_pend = 0;
            m_step = 1;
        end else if (opcode_decode == c_OP_LDM || opcode_decode == c_OP_IADD) begin
            m_op = opcode_decode; m_rs = Rs_decode; m_rd = Rd_decode; m_pc = pc_decode;
            m_immw = 1;
        end else begin
            e_valid = 1; e_uop = 0;
            e_op = opcode_decode; e_rs = Rs_decode; e_rd = Rd_decode; e_sh = shmnt_decode;
            e_imm = 16'h0000; e_pc = pc_decode;
        end
    endtask

    always @(negedge rst_n) model_reset();

    always @(negedge clk) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    // Compare process: every cycle, after the DUT's negedge update
    always @(negedge clk) begin
        #1;
        chk("busy", busy, 32'(m_immw || m_step != 0));
        chk("fd_enable", fd_enable, 32'(!stall_in && m_step != 1 && m_step != 2));
        chk("de_valid", de_valid, 32'(e_valid));
        chk("de_uop", de_uop, e_valid ? 32'(e_uop) : 32'd0);
        if (e_valid) begin
            if (e_uop == 0 || e_uop == 1) begin
                chk("de_opcode", de_opcode, e_op);
                chk("de_rs", de_rs, e_rs);
                chk("de_rd", de_rd, e_rd);
            end
            if (e_uop == 0) chk("de_shmnt", de_shmnt, e_sh);
            if (e_uop == 0 || e_uop == 1 || e_uop == 4) chk("de_imm", de_imm, e_imm);
            if (e_uop <= 3) chk("de_pc", de_pc, e_pc);
        end
    end

    task automatic drive(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rd,
                         input logic [4:0] sh, input logic [31:0] pc,
                         input logic i1, input logic i2, input logic st);
        @(posedge clk);
        opcode_decode = op; Rs_decode = rs; Rd_decode = rd; shmnt_decode = sh;
        pc_decode = pc; int1_decode = i1; int2_decode = i2; stall_in = st;
        @(negedge clk);
        #2;
    endtask

    int fd_low;

    initial begin
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", de_valid, 0);
        chk("reset_busy", busy, 0);
        chk("reset_imm", de_imm, 0);
        chk("reset_pc", de_pc, 0);
        @(posedge clk);
        rst_n = 1'b1;

        // NORMAL pass-through
        drive(5'b00011, 3'd2, 3'd5, 5'd4, 32'h10, 0, 0, 0);
        chk("normal_valid", de_valid, 1);
        chk("normal_uop", de_uop, 0);
        chk("normal_rs", de_rs, 2);
        chk("normal_rd", de_rd, 5);
        chk("normal_shmnt", de_shmnt, 4);
        chk("normal_pc", de_pc, 32'h10);
        drive(5'b00000, 3'd0, 3'd0, 5'd0, 32'h14, 0, 0, 0);
        chk("nop_valid", de_valid, 1);

        // Two-word immediate
        drive(c_OP_LDM, 3'd1, 3'd3, 5'd0, 32'h20, 0, 0, 0);
        chk("ldm_bubble", de_valid, 0);
        chk("ldm_fd_en", fd_enable, 1);
        drive(5'b00001, 3'd2, 3'd7, 5'd9, 32'h24, 0, 0, 0);
        chk("imm_uop", de_uop, 1);
        chk("imm_rd", de_rd, 3);
        chk("imm_pc", de_pc, 32'h20);
        chk("imm_value", de_imm, 16'h0AE9);
        chk("imm_fd_en", fd_enable, 1);

        // int1 entry sequence; tag stays on the held word and must be ignored
        fd_low = 0;
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h40, 1, 0, 0);
        chk("int_pushpc_uop", de_uop, 2);
        chk("int_pushpc_pc", de_pc, 32'h40);
        if (!fd_enable) fd_low++;
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h40, 1, 0, 0);
        chk("int_flags_uop", de_uop, 3);
        if (!fd_enable) fd_low++;
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h40, 1, 0, 0);
        chk("int_jump_uop", de_uop, 4);
        chk("int_jump_vec", de_imm, 16'h0000);
        if (!fd_enable) fd_low++;
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h44, 1, 0, 0);
        chk("int_bubble1", de_valid, 0);
        if (!fd_enable) fd_low++;
        drive(5'b00001, 3'd0, 3'd0, 5'd0, 32'h100, 0, 0, 0);
        chk("int_bubble2", de_valid, 0);
        if (!fd_enable) fd_low++;
        chk("int_fd_low_count", fd_low, 2);
        drive(5'b00001, 3'd1, 3'd1, 5'd1, 32'h104, 0, 0, 0);
        chk("post_int_normal", de_uop, 0);

        // int1 and int2 together: single entry with vector 1
        drive(5'b00010, 3'd0, 3'd0, 5'd0, 32'h50, 1, 1, 0);
        chk("both_pushpc", de_uop, 2);
        repeat (2) drive(5'b00010, 3'd0, 3'd0, 5'd0, 32'h50, 0, 0, 0);
        chk("both_vec", de_imm, 16'h0000);
        repeat (2) drive(5'b00000, 3'd0, 3'd0, 5'd0, 32'h200, 0, 0, 0);
        drive(5'b00000, 3'd0, 3'd0, 5'd0, 32'h204, 0, 0, 0);
        chk("both_no_second", de_uop, 0);

        // Interrupt on immediate data word is deferred
        drive(c_OP_IADD, 3'd4, 3'd1, 5'd0, 32'h60, 0, 0, 0);
        drive(5'h1F, 3'd7, 3'd7, 5'd31, 32'h64, 0, 1, 0);
        chk("iadd_uop", de_uop, 1);
        chk("iadd_imm", de_imm, 16'hFFFF);
        chk("iadd_pc", de_pc, 32'h60);
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h68, 0, 0, 0);
        chk("defer_pushpc", de_uop, 2);
        chk("defer_pc", de_pc, 32'h68);
        repeat (2) drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h68, 0, 0, 0);
        chk("defer_vec", de_imm, 16'h0002);
        repeat (2) drive(5'b00000, 3'd0, 3'd0, 5'd0, 32'h300, 0, 0, 0);

        // Stall while waiting for the immediate
        drive(c_OP_LDM, 3'd0, 3'd6, 5'd0, 32'h80, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            drive(5'b00010, 3'd1, 3'd4, 5'd3, 32'h84, 0, 0, 1);
            chk("stall_bubble", de_valid, 0);
            chk("stall_fd_en", fd_enable, 0);
            chk("stall_busy", busy, 1);
        end
        drive(5'b00010, 3'd1, 3'd4, 5'd3, 32'h84, 0, 0, 0);
        chk("stall_imm_uop", de_uop, 1);
        chk("stall_imm_val", de_imm, 16'h1183);
        chk("stall_imm_rd", de_rd, 6);

        // Reset asserted while in INT_FLG
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h90, 0, 1, 0);
        drive(5'b00011, 3'd0, 3'd0, 5'd0, 32'h90, 0, 0, 0);
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        chk("midreset_valid", de_valid, 0);
        chk("midreset_uop", de_uop, 0);
        chk("midreset_busy", busy, 0);
        chk("midreset_fd_en", fd_enable, 1);
        @(posedge clk);
        rst_n = 1'b1;
        drive(5'b00101, 3'd3, 3'd2, 5'd1, 32'hA0, 0, 0, 0);
        chk("after_reset_normal", de_uop, 0);
        chk("after_reset_pc", de_pc, 32'hA0);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
